// File: rtl/rv_dmem_bridge_if.sv
// CPU data-port and Wishbone-classic signal bundle for rv_dmem_bridge.
// The bridge takes the slave view (it serves the CPU); the environment takes the master view.
interface rv_dmem_bridge_if;
  logic [31:0] dm_addr_i;
  logic [31:0] dm_data_s_i;
  logic [3:0]  dm_data_select_i;
  logic        dm_load_i;
  logic        dm_store_i;
  logic        dm_ready_o;
  logic [31:0] dm_data_l_o;
  logic        dm_load_done_o;
  logic        dm_store_done_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [31:0] wb_adr_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        wb_err_i;
  logic        err_o;
  logic [31:0] err_addr_o;

  modport slave (
    input  dm_addr_i, dm_data_s_i, dm_data_select_i, dm_load_i, dm_store_i,
    output dm_ready_o, dm_data_l_o, dm_load_done_o, dm_store_done_o,
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
    input  wb_dat_i, wb_ack_i, wb_err_i,
    output err_o, err_addr_o
  );

  modport master (
    output dm_addr_i, dm_data_s_i, dm_data_select_i, dm_load_i, dm_store_i,
    input  dm_ready_o, dm_data_l_o, dm_load_done_o, dm_store_done_o,
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
    output wb_dat_i, wb_ack_i, wb_err_i,
    input  err_o, err_addr_o
  );
endinterface

// File: rtl/rv_dmem_bridge.sv
// uRV data-port to Wishbone-classic bridge: one bus cycle per load/store strobe,
// with per-transfer timeout and error reporting so a dead slave cannot stall the core.
module rv_dmem_bridge #(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input logic           clk_i,
  input logic           rst_i,
  rv_dmem_bridge_if.slave bus
);

  localparam int unsigned    CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, LOAD, STORE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q;
  logic [31:0]      addr_q, wdat_q;
  logic [3:0]       sel_q;
  logic             we_q;
  logic [31:0]      data_l_q, err_addr_q;
  logic             load_done_q, store_done_q, err_q;
  logic             accept, term_ack, term_fail, timeout_hit;

  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    term_ack    = 1'b0;
    term_fail   = 1'b0;
    timeout_hit = (TIMEOUT != 0) && (wait_cnt_q == CNT_LAST);
    unique case (state_q)
      IDLE: begin
        // Store has priority; a load strobed in the same cycle is dropped.
        if (bus.dm_store_i) begin
          state_d = STORE;
          accept  = 1'b1;
        end else if (bus.dm_load_i) begin
          state_d = LOAD;
          accept  = 1'b1;
        end
      end
      LOAD, STORE: begin
        if (bus.wb_ack_i)                      term_ack  = 1'b1;
        else if (bus.wb_err_i || timeout_hit)  term_fail = 1'b1;
        if (term_ack || term_fail) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= (state_q == IDLE) ? '0 : wait_cnt_q + 1'b1;
    end
  end

  // Request capture: bus-facing fields stay put until the next accepted request.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q <= '0;
      wdat_q <= '0;
      sel_q  <= '0;
      we_q   <= 1'b0;
    end else if (accept) begin
      addr_q <= bus.dm_addr_i;
      wdat_q <= bus.dm_data_s_i;
      sel_q  <= bus.dm_data_select_i;
      we_q   <= bus.dm_store_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_l_q     <= '0;
      err_addr_q   <= '0;
      load_done_q  <= 1'b0;
      store_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      load_done_q  <= 1'b0;
      store_done_q <= 1'b0;
      err_q        <= 1'b0;
      if (term_ack || term_fail) begin
        load_done_q  <= (state_q == LOAD);
        store_done_q <= (state_q == STORE);
        if (state_q == LOAD) data_l_q <= term_ack ? bus.wb_dat_i : ERR_DATA;
        if (term_fail) begin
          err_q      <= 1'b1;
          err_addr_q <= addr_q;
        end
      end
    end
  end

  assign bus.dm_ready_o      = (state_q == IDLE);
  assign bus.wb_cyc_o        = (state_q != IDLE);
  assign bus.wb_stb_o        = (state_q != IDLE);
  assign bus.wb_we_o         = we_q;
  assign bus.wb_adr_o        = {addr_q[31:2], 2'b00};
  assign bus.wb_sel_o        = sel_q;
  assign bus.wb_dat_o        = wdat_q;
  assign bus.dm_data_l_o     = data_l_q;
  assign bus.dm_load_done_o  = load_done_q;
  assign bus.dm_store_done_o = store_done_q;
  assign bus.err_o           = err_q;
  assign bus.err_addr_o      = err_addr_q;

endmodule

// File: tb/tb_rv_dmem_bridge.sv
// Scoreboard bench for rv_dmem_bridge with a programmable Wishbone slave.
module tb_rv_dmem_bridge;
  localparam int unsigned TO      = 8;
  localparam logic [31:0] ERR_VAL = 32'hDEADBEEF;
  localparam int M_ACK = 0, M_ERR = 1, M_SILENT = 2, M_BOTH = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  rv_dmem_bridge_if bus();

  rv_dmem_bridge #(.TIMEOUT(TO), .ERR_DATA(ERR_VAL)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_load;
    logic [31:0] data;
    bit          err;
    logic [31:0] addr;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int checks = 0, failures = 0;
  int cyc_hi = 0, done_cnt = 0, last_wait_n = 0;
  logic [31:0] last_adr = '0, last_dat = '0;
  logic [3:0]  last_sel = '0;
  logic        last_we  = 1'b0;

  int          slave_wait = 0, slave_mode = M_ACK, bus_cnt = 0;
  logic [31:0] slave_data = '0;

  // Wishbone slave: answers on bus cycle number slave_wait of each transfer.
  always @(negedge clk) begin
    bus.wb_ack_i = 1'b0;
    bus.wb_err_i = 1'b0;
    bus.wb_dat_i = 32'h0;
    if (bus.wb_cyc_o === 1'b1) begin
      if (bus_cnt == slave_wait) begin
        case (slave_mode)
          M_ACK:  begin bus.wb_ack_i = 1'b1; bus.wb_dat_i = slave_data; end
          M_ERR:  bus.wb_err_i = 1'b1;
          M_BOTH: begin bus.wb_ack_i = 1'b1; bus.wb_err_i = 1'b1; bus.wb_dat_i = slave_data; end
          default: ;
        endcase
      end
      bus_cnt++;
    end else begin
      bus_cnt = 0;
    end
  end

  // Response monitor: pops the scoreboard on every done pulse.
  always @(negedge clk) begin
    if (bus.wb_cyc_o === 1'b1) begin
      cyc_hi++;
      last_adr = bus.wb_adr_o;
      last_dat = bus.wb_dat_o;
      last_sel = bus.wb_sel_o;
      last_we  = bus.wb_we_o;
    end
    if (bus.dm_load_done_o === 1'b1 || bus.dm_store_done_o === 1'b1) begin
      done_cnt++;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_done load=%b store=%b expected no done", bus.dm_load_done_o, bus.dm_store_done_o);
      end else begin
        mon_e = sb.pop_front();
        checks++;
        if ({bus.dm_load_done_o, bus.dm_store_done_o} !== {mon_e.is_load, ~mon_e.is_load}) begin
          failures++;
          $display("FAIL done_kind got=%b%b expected=%b%b", bus.dm_load_done_o, bus.dm_store_done_o, mon_e.is_load, ~mon_e.is_load);
        end
        if (mon_e.is_load) begin
          checks++;
          if (bus.dm_data_l_o !== mon_e.data) begin
            failures++;
            $display("FAIL load_data got=%h expected=%h", bus.dm_data_l_o, mon_e.data);
          end
        end
        checks++;
        if (bus.err_o !== mon_e.err) begin
          failures++;
          $display("FAIL err_pulse got=%b expected=%b", bus.err_o, mon_e.err);
        end
        if (mon_e.err) begin
          checks++;
          if (bus.err_addr_o !== mon_e.addr) begin
            failures++;
            $display("FAIL err_addr got=%h expected=%h", bus.err_addr_o, mon_e.addr);
          end
        end
      end
    end else if (rst === 1'b0) begin
      checks++;
      if (bus.err_o !== 1'b0) begin
        failures++;
        $display("FAIL stray_err got=%b expected=0", bus.err_o);
      end
    end
  end

  task automatic issue(input bit st, input bit ld, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s);
    exp_t e;
    int n = 0;
    @(negedge clk);
    while (bus.dm_ready_o !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    last_wait_n = n;
    checks++;
    if (bus.dm_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL issue_ready got=%b expected=1", bus.dm_ready_o);
    end
    bus.dm_addr_i        = a;
    bus.dm_data_s_i      = d;
    bus.dm_data_select_i = s;
    bus.dm_store_i       = st;
    bus.dm_load_i        = ld;
    e.is_load = !st;
    e.err     = (slave_mode == M_ERR) || (slave_mode == M_SILENT);
    e.data    = e.err ? ERR_VAL : slave_data;
    e.addr    = a;
    sb.push_back(e);
    @(negedge clk);
    bus.dm_store_i = 1'b0;
    bus.dm_load_i  = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL %s_completion pending=%0d expected=0", name, sb.size());
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    bus.dm_addr_i = '0; bus.dm_data_s_i = '0; bus.dm_data_select_i = '0;
    bus.dm_load_i = 1'b0; bus.dm_store_i = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks += 10;
    if (bus.dm_ready_o !== 1'b1)     begin failures++; $display("FAIL rst_ready got=%b expected=1", bus.dm_ready_o); end
    if (bus.wb_cyc_o !== 1'b0)       begin failures++; $display("FAIL rst_cyc got=%b expected=0", bus.wb_cyc_o); end
    if (bus.wb_stb_o !== 1'b0)       begin failures++; $display("FAIL rst_stb got=%b expected=0", bus.wb_stb_o); end
    if (bus.wb_we_o !== 1'b0)        begin failures++; $display("FAIL rst_we got=%b expected=0", bus.wb_we_o); end
    if (bus.wb_adr_o !== 32'h0)      begin failures++; $display("FAIL rst_adr got=%h expected=0", bus.wb_adr_o); end
    if (bus.wb_dat_o !== 32'h0)      begin failures++; $display("FAIL rst_dat got=%h expected=0", bus.wb_dat_o); end
    if (bus.wb_sel_o !== 4'h0)       begin failures++; $display("FAIL rst_sel got=%h expected=0", bus.wb_sel_o); end
    if (bus.dm_data_l_o !== 32'h0)   begin failures++; $display("FAIL rst_data_l got=%h expected=0", bus.dm_data_l_o); end
    if ({bus.dm_load_done_o, bus.dm_store_done_o, bus.err_o} !== 3'b000)
                                     begin failures++; $display("FAIL rst_pulses got=%b%b%b expected=000", bus.dm_load_done_o, bus.dm_store_done_o, bus.err_o); end
    if (bus.err_addr_o !== 32'h0)    begin failures++; $display("FAIL rst_err_addr got=%h expected=0", bus.err_addr_o); end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.dm_ready_o !== 1'b1 || bus.wb_cyc_o !== 1'b0) begin
      failures++;
      $display("FAIL rst_release ready=%b cyc=%b expected ready=1 cyc=0", bus.dm_ready_o, bus.wb_cyc_o);
    end
  endtask

  task automatic test_load_wait();
    slave_mode = M_ACK; slave_wait = 3; slave_data = 32'h12345678;
    cyc_hi = 0; done_cnt = 0;
    issue(1'b0, 1'b1, 32'h0000_0040, 32'h0, 4'hF);
    wait_done("load_wait");
    checks += 2;
    if (cyc_hi != 4)   begin failures++; $display("FAIL load_wait_cyc got=%0d expected=4", cyc_hi); end
    if (done_cnt != 1) begin failures++; $display("FAIL load_wait_dones got=%0d expected=1", done_cnt); end
  endtask

  task automatic test_store();
    slave_mode = M_ACK; slave_wait = 0; slave_data = 32'h0;
    cyc_hi = 0; done_cnt = 0;
    issue(1'b1, 1'b0, 32'h0000_1003, 32'hAABBCCDD, 4'b1000);
    @(negedge clk);
    checks += 5;
    if (bus.dm_store_done_o !== 1'b1) begin failures++; $display("FAIL store_latency got=%b expected=1", bus.dm_store_done_o); end
    if (last_adr !== 32'h0000_1000)   begin failures++; $display("FAIL store_adr got=%h expected=00001000", last_adr); end
    if (last_we !== 1'b1)             begin failures++; $display("FAIL store_we got=%b expected=1", last_we); end
    if (last_sel !== 4'b1000)         begin failures++; $display("FAIL store_sel got=%b expected=1000", last_sel); end
    if (last_dat !== 32'hAABBCCDD)    begin failures++; $display("FAIL store_dat got=%h expected=aabbccdd", last_dat); end
    wait_done("store");
    checks++;
    if (cyc_hi != 1) begin failures++; $display("FAIL store_cyc got=%0d expected=1", cyc_hi); end
  endtask

  task automatic test_both_strobes();
    slave_mode = M_ACK; slave_wait = 0; slave_data = 32'h5555AAAA;
    cyc_hi = 0; done_cnt = 0;
    issue(1'b1, 1'b1, 32'h0000_2000, 32'h11112222, 4'hF);
    wait_done("both");
    checks += 3;
    if (done_cnt != 1) begin failures++; $display("FAIL both_dones got=%0d expected=1", done_cnt); end
    if (cyc_hi != 1)   begin failures++; $display("FAIL both_cyc got=%0d expected=1", cyc_hi); end
    if (last_we !== 1'b1) begin failures++; $display("FAIL both_we got=%b expected=1", last_we); end
  endtask

  task automatic test_timeout();
    slave_mode = M_SILENT; slave_wait = 0;
    cyc_hi = 0; done_cnt = 0;
    issue(1'b0, 1'b1, 32'h0000_3006, 32'h0, 4'hF);
    wait_done("timeout");
    checks += 3;
    if (cyc_hi != TO)  begin failures++; $display("FAIL timeout_cyc got=%0d expected=%0d", cyc_hi, TO); end
    if (done_cnt != 1) begin failures++; $display("FAIL timeout_dones got=%0d expected=1", done_cnt); end
    if (bus.err_addr_o !== 32'h0000_3006) begin failures++; $display("FAIL timeout_err_addr_held got=%h expected=00003006", bus.err_addr_o); end
  endtask

  task automatic test_ack_err();
    slave_mode = M_BOTH; slave_wait = 1; slave_data = 32'hCAFEF00D;
    done_cnt = 0;
    issue(1'b0, 1'b1, 32'h0000_4000, 32'h0, 4'hF);
    wait_done("ack_err_both");
    slave_mode = M_ERR; slave_wait = 2;
    issue(1'b0, 1'b1, 32'h0000_500C, 32'h0, 4'hF);
    wait_done("err_only");
    checks += 2;
    if (done_cnt != 2) begin failures++; $display("FAIL ack_err_dones got=%0d expected=2", done_cnt); end
    if (bus.err_addr_o !== 32'h0000_500C) begin failures++; $display("FAIL err_only_addr got=%h expected=0000500c", bus.err_addr_o); end
  endtask

  task automatic test_back_to_back();
    slave_mode = M_ACK; slave_wait = 0; slave_data = 32'h0BADF00D;
    cyc_hi = 0; done_cnt = 0;
    issue(1'b1, 1'b0, 32'h0000_7000, 32'h01020304, 4'b0011);
    issue(1'b0, 1'b1, 32'h0000_7004, 32'h0, 4'hF);
    checks++;
    if (last_wait_n != 0) begin failures++; $display("FAIL b2b_ready_stall1 got=%0d expected=0", last_wait_n); end
    issue(1'b0, 1'b1, 32'h0000_7008, 32'h0, 4'hF);
    checks++;
    if (last_wait_n != 0) begin failures++; $display("FAIL b2b_ready_stall2 got=%0d expected=0", last_wait_n); end
    wait_done("b2b");
    checks += 2;
    if (done_cnt != 3) begin failures++; $display("FAIL b2b_dones got=%0d expected=3", done_cnt); end
    if (cyc_hi != 3)   begin failures++; $display("FAIL b2b_cyc got=%0d expected=3", cyc_hi); end
  endtask

  task automatic test_reset_mid();
    slave_mode = M_SILENT; slave_wait = 0;
    issue(1'b0, 1'b1, 32'h0000_6000, 32'h0, 4'hF);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    sb.delete();
    #1;
    checks++;
    if ({bus.wb_cyc_o, bus.wb_stb_o, bus.dm_ready_o} !== 3'b001) begin
      failures++;
      $display("FAIL mid_rst_async cyc/stb/ready got=%b%b%b expected=001", bus.wb_cyc_o, bus.wb_stb_o, bus.dm_ready_o);
    end
    done_cnt = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks += 2;
    if (done_cnt != 0) begin failures++; $display("FAIL mid_rst_no_done got=%0d expected=0", done_cnt); end
    if (bus.dm_ready_o !== 1'b1) begin failures++; $display("FAIL mid_rst_ready got=%b expected=1", bus.dm_ready_o); end
    slave_mode = M_ACK; slave_wait = 1; slave_data = 32'h600DCAFE;
    issue(1'b0, 1'b1, 32'h0000_6010, 32'h0, 4'hF);
    wait_done("post_reset");
    checks++;
    if (done_cnt != 1) begin failures++; $display("FAIL post_reset_dones got=%0d expected=1", done_cnt); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load_wait();
    test_store();
    test_both_strobes();
    test_timeout();
    test_ack_err();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
